// File: rtl/mem_arbiter.sv
// Shared memory-port arbiter: muxes icache and dcache misses onto one tagged bus,
// tracks outstanding load tags and steers tagged returns back to their owner.
module mem_arbiter #(
  parameter int NUM_TAGS     = 15,
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic            clock,
  input  logic            reset,
  // icache side
  input  logic            ic_req,
  input  logic [XLEN-1:0] ic_addr,
  input  logic            ic_squash,
  output logic            ic_accept,
  output logic [3:0]      ic_tag,
  output logic            ic_rsp_valid,
  output logic [63:0]     ic_rsp_data,
  output logic [3:0]      ic_rsp_tag,
  // dcache side
  input  logic            dc_req,
  input  logic [1:0]      dc_cmd,
  input  logic [XLEN-1:0] dc_addr,
  input  logic [63:0]     dc_wdata,
  output logic            dc_accept,
  output logic [3:0]      dc_tag,
  output logic            dc_rsp_valid,
  output logic [63:0]     dc_rsp_data,
  output logic [3:0]      dc_rsp_tag,
  // memory bus
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  // status
  output logic [4:0]      outstanding_cnt,
  output logic            tag_err
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int             SW         = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [4:0]     CNT_FULL   = 5'(NUM_TAGS);

  // Handshake: a requester raises x_req and holds it (with its payload) until
  // the cycle x_accept = 1; x_tag is only meaningful in that accept cycle.
  // Responses are single-cycle pulses with no back-pressure.

  logic [SW-1:0] starve_cnt;
  logic [15:0]   tbl_valid;
  logic [15:0]   tbl_ic;
  logic [15:0]   tbl_stale;

  logic dc_is_load, dc_is_store, table_full;
  logic ic_eligible, dc_eligible, ic_priority;
  logic grant_ic, grant_dc, mem_ready;
  logic alloc, alloc_new;
  logic ret_nonzero, ret_hit, ret_miss, ret_live;

  // ---------------------------------------------------------------- arbitration
  assign dc_is_load  = dc_req & (dc_cmd == BUS_LOAD);
  assign dc_is_store = dc_req & (dc_cmd == BUS_STORE);
  assign table_full  = (outstanding_cnt == CNT_FULL);

  // A full tag table blocks loads only; stores never consume a tag.
  assign ic_eligible = reset & ic_req & ~ic_squash & ~table_full;
  assign dc_eligible = reset & (dc_is_store | (dc_is_load & ~table_full));
  assign ic_priority = ic_req & (starve_cnt == STARVE_MAX);

  assign grant_ic  = ic_eligible & (ic_priority | ~dc_eligible);
  assign grant_dc  = dc_eligible & ~grant_ic;
  assign mem_ready = (mem2proc_response != 4'd0);

  assign ic_accept = grant_ic & mem_ready;
  assign dc_accept = grant_dc & mem_ready;
  assign ic_tag    = ic_accept ? mem2proc_response : 4'd0;
  assign dc_tag    = dc_accept ? mem2proc_response : 4'd0;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_ic) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = ic_addr;
    end else if (grant_dc) begin
      proc2mem_command = dc_cmd;
      proc2mem_addr    = dc_addr;
      proc2mem_data    = dc_wdata;
    end
  end

  // ---------------------------------------------------------------- returns
  assign ret_nonzero = reset & (mem2proc_tag != 4'd0);
  assign ret_hit     = ret_nonzero & tbl_valid[mem2proc_tag];
  assign ret_miss    = ret_nonzero & ~tbl_valid[mem2proc_tag];
  assign ret_live    = ret_hit & ~tbl_stale[mem2proc_tag];

  assign ic_rsp_valid = ret_live & tbl_ic[mem2proc_tag];
  assign dc_rsp_valid = ret_live & ~tbl_ic[mem2proc_tag];
  assign ic_rsp_data  = ic_rsp_valid ? mem2proc_data : 64'd0;
  assign ic_rsp_tag   = ic_rsp_valid ? mem2proc_tag  : 4'd0;
  assign dc_rsp_data  = dc_rsp_valid ? mem2proc_data : 64'd0;
  assign dc_rsp_tag   = dc_rsp_valid ? mem2proc_tag  : 4'd0;

  // Only a load consumes a tag; re-using a tag freed this same cycle keeps the count flat.
  assign alloc     = ic_accept | (dc_accept & dc_is_load);
  assign alloc_new = alloc & (~tbl_valid[mem2proc_response] |
                              (ret_hit & (mem2proc_tag == mem2proc_response)));

  // ---------------------------------------------------------------- state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tbl_valid <= '0;
      tbl_ic    <= '0;
      tbl_stale <= '0;
    end else begin
      if (ic_squash) begin
        tbl_stale <= tbl_stale | (tbl_valid & tbl_ic);
      end
      // Release before allocate so a same-cycle re-accept of the tag wins.
      if (ret_hit) begin
        tbl_valid[mem2proc_tag] <= 1'b0;
      end
      if (alloc) begin
        tbl_valid[mem2proc_response] <= 1'b1;
        tbl_ic[mem2proc_response]    <= ic_accept;
        tbl_stale[mem2proc_response] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outstanding_cnt <= 5'd0;
    end else begin
      outstanding_cnt <= outstanding_cnt + {4'd0, alloc_new} - {4'd0, ret_hit};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!ic_req || ic_accept) begin
      starve_cnt <= '0;
    end else if (dc_accept && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_err <= 1'b0;
    end else if (ret_miss) begin
      tag_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- properties
  a_cnt_bound: assert property (@(posedge clock) disable iff (!reset)
    outstanding_cnt <= CNT_FULL);
  a_one_grant: assert property (@(posedge clock) disable iff (!reset)
    !(grant_ic && grant_dc));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter: a tag-table reference model feeds
// expected-result queues that an independent monitor drains against DUT outputs.
module tb_mem_arbiter;

  localparam int NUM_TAGS     = 15;
  localparam int STARVE_LIMIT = 4;
  localparam int XLEN         = 32;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  // ---------------------------------------------------------------- clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #10 clock = ~clock;

  logic            ic_req = 0, ic_squash = 0, dc_req = 0;
  logic [XLEN-1:0] ic_addr = '0, dc_addr = '0;
  logic [1:0]      dc_cmd = BUS_NONE;
  logic [63:0]     dc_wdata = '0, mem2proc_data = '0;
  logic [3:0]      mem2proc_response = '0, mem2proc_tag = '0;
  logic            ic_accept, ic_rsp_valid, dc_accept, dc_rsp_valid, tag_err;
  logic [3:0]      ic_tag, ic_rsp_tag, dc_tag, dc_rsp_tag;
  logic [63:0]     ic_rsp_data, dc_rsp_data, proc2mem_data;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [4:0]      outstanding_cnt;

  mem_arbiter #(.NUM_TAGS(NUM_TAGS), .STARVE_LIMIT(STARVE_LIMIT), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_squash(ic_squash),
    .ic_accept(ic_accept), .ic_tag(ic_tag),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .ic_rsp_tag(ic_rsp_tag),
    .dc_req(dc_req), .dc_cmd(dc_cmd), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_accept(dc_accept), .dc_tag(dc_tag),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data), .dc_rsp_tag(dc_rsp_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .outstanding_cnt(outstanding_cnt), .tag_err(tag_err)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [97:0] issue_q[$];
  logic [3:0]  ic_acc_q[$], dc_acc_q[$];
  logic [67:0] ic_rsp_q[$], dc_rsp_q[$];
  logic [3:0]  mem_inflight[$];
  logic [4:0]  exp_cnt = '0;
  logic        exp_err = 1'b0;
  bit          mon_on = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  bit m_valid[16], m_owner_ic[16], m_stale[16];
  int m_starve;
  bit m_err;
  bit m_ic_acc, m_dc_acc;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_owner_ic[i] = 0; m_stale[i] = 0;
    end
    m_starve = 0;
    m_err = 0;
  endtask

  // Predicts this cycle's outputs from the inputs now applied, then advances to the next edge.
  task automatic model_step();
    int cnt;
    bit full, dc_ld, dc_st, ic_can, dc_can, ic_win, dc_win;
    logic [3:0] rt, at;
    m_ic_acc = 0;
    m_dc_acc = 0;
    if (!reset) begin
      model_clear();
      exp_cnt = 5'd0;
      exp_err = 1'b0;
      return;
    end
    cnt = 0;
    for (int i = 1; i < 16; i++) cnt += int'(m_valid[i]);
    exp_cnt = 5'(cnt);
    exp_err = m_err;
    full   = (cnt >= NUM_TAGS);
    dc_ld  = dc_req && (dc_cmd == BUS_LOAD);
    dc_st  = dc_req && (dc_cmd == BUS_STORE);
    ic_can = ic_req && !ic_squash && !full;
    dc_can = dc_st || (dc_ld && !full);
    ic_win = ic_can && (!dc_can || (m_starve == STARVE_LIMIT));
    dc_win = dc_can && !ic_win;
    if (ic_win) issue_q.push_back({BUS_LOAD, ic_addr, 64'd0});
    if (dc_win) issue_q.push_back({dc_cmd, dc_addr, dc_wdata});
    at = mem2proc_response;
    m_ic_acc = ic_win && (at != 0);
    m_dc_acc = dc_win && (at != 0);
    if (m_ic_acc) ic_acc_q.push_back(at);
    if (m_dc_acc) dc_acc_q.push_back(at);
    rt = mem2proc_tag;
    if (rt != 0) begin
      for (int k = mem_inflight.size() - 1; k >= 0; k--)
        if (mem_inflight[k] == rt) mem_inflight.delete(k);
      if (m_valid[rt]) begin
        if (!m_stale[rt]) begin
          if (m_owner_ic[rt]) ic_rsp_q.push_back({mem2proc_data, rt});
          else                dc_rsp_q.push_back({mem2proc_data, rt});
        end
        m_valid[rt] = 0;
      end else begin
        m_err = 1;
      end
    end
    if (ic_squash)
      for (int i = 0; i < 16; i++) if (m_valid[i] && m_owner_ic[i]) m_stale[i] = 1;
    if (m_ic_acc || (m_dc_acc && dc_ld)) begin
      m_valid[at] = 1; m_owner_ic[at] = m_ic_acc; m_stale[at] = 0;
      mem_inflight.push_back(at);
    end
    if (!ic_req || m_ic_acc) m_starve = 0;
    else if (m_dc_acc && m_starve < STARVE_LIMIT) m_starve++;
  endtask

  // ---------------------------------------------------------------- monitor
  logic [97:0] e98;
  logic [67:0] e68;
  logic [3:0]  e4;

  always @(negedge clock) begin
    #2;
    if (mon_on) begin
      if (proc2mem_command != BUS_NONE && issue_q.size() > 0) begin
        e98 = issue_q.pop_front();
        check("issue", {proc2mem_command, proc2mem_addr, proc2mem_data}, e98);
      end else check("bus_idle", {proc2mem_command, proc2mem_addr, proc2mem_data}, 98'd0);
      if (ic_accept && ic_acc_q.size() > 0) begin
        e4 = ic_acc_q.pop_front();
        check("ic_tag", ic_tag, e4);
      end else check("ic_accept", ic_accept, 1'b0);
      if (dc_accept && dc_acc_q.size() > 0) begin
        e4 = dc_acc_q.pop_front();
        check("dc_tag", dc_tag, e4);
      end else check("dc_accept", dc_accept, 1'b0);
      if (ic_rsp_valid && ic_rsp_q.size() > 0) begin
        e68 = ic_rsp_q.pop_front();
        check("ic_rsp", {ic_rsp_data, ic_rsp_tag}, e68);
      end else check("ic_rsp_idle", {ic_rsp_valid, ic_rsp_data, ic_rsp_tag}, 69'd0);
      if (dc_rsp_valid && dc_rsp_q.size() > 0) begin
        e68 = dc_rsp_q.pop_front();
        check("dc_rsp", {dc_rsp_data, dc_rsp_tag}, e68);
      end else check("dc_rsp_idle", {dc_rsp_valid, dc_rsp_data, dc_rsp_tag}, 69'd0);
      check("outstanding_cnt", outstanding_cnt, exp_cnt);
      check("tag_err", tag_err, exp_err);
      check("issue_missing",  issue_q.size(),  0);
      check("ic_acc_missing", ic_acc_q.size(), 0);
      check("dc_acc_missing", dc_acc_q.size(), 0);
      check("ic_rsp_missing", ic_rsp_q.size(), 0);
      check("dc_rsp_missing", dc_rsp_q.size(), 0);
      issue_q.delete(); ic_acc_q.delete(); dc_acc_q.delete();
      ic_rsp_q.delete(); dc_rsp_q.delete();
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic cyc(input bit icr, input bit sq, input bit dcr, input logic [1:0] cmd,
                     input logic [3:0] resp, input logic [3:0] rt);
    @(negedge clock);
    ic_req = icr; ic_squash = sq; dc_req = dcr; dc_cmd = cmd;
    ic_addr = $urandom; dc_addr = $urandom; dc_wdata = {$urandom, $urandom};
    mem2proc_response = resp; mem2proc_tag = rt; mem2proc_data = {$urandom, $urandom};
    #1 model_step();
    mon_on = 1;
    #3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, BUS_NONE, 4'd0, 4'd0);
  endtask

  function automatic logic [3:0] pick_free();
    logic [3:0] cand[$];
    bit used;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      used = 0;
      foreach (mem_inflight[k]) if (mem_inflight[k] == 4'(t)) used = 1;
      if (!used) cand.push_back(4'(t));
    end
    if (cand.size() == 0) return 4'd0;
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  task automatic drain();
    while (mem_inflight.size() > 0) cyc(0, 0, 0, BUS_NONE, 4'd0, mem_inflight[0]);
  endtask

  // ---------------------------------------------------------------- stimulus
  bit         ic_p, dc_p, sq;
  logic [1:0] dcmd;
  logic [3:0] resp, rt;

  initial begin
    model_clear();
    // Requests and a ready memory during reset must produce nothing.
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, BUS_LOAD, 4'd3, 4'd0);
    idle(1);
    reset = 1'b1;
    idle(2);

    // Both request, memory offers tag 3: dcache wins.
    cyc(1, 0, 1, BUS_LOAD, 4'd3, 4'd0);
    cyc(1, 0, 0, BUS_NONE, 4'd4, 4'd0);
    cyc(0, 0, 0, BUS_NONE, 4'd0, 4'd3);
    cyc(0, 0, 0, BUS_NONE, 4'd0, 4'd4);

    // icache starvation guard with dcache loads streaming.
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, BUS_LOAD, pick_free(), 4'd0);
    drain();

    // Squashed icache fill is dropped; squash blocks icache but not a dcache store.
    cyc(1, 0, 0, BUS_NONE, 4'd5, 4'd0);
    cyc(0, 1, 0, BUS_NONE, 4'd0, 4'd0);
    cyc(0, 0, 0, BUS_NONE, 4'd0, 4'd5);
    cyc(1, 1, 1, BUS_STORE, 4'd2, 4'd0);
    cyc(1, 1, 0, BUS_NONE, 4'd2, 4'd0);
    idle(1);

    // Fill all tags, then loads stall while stores pass; a return frees a slot.
    for (int i = 0; i < NUM_TAGS; i++) cyc(0, 0, 1, BUS_LOAD, pick_free(), 4'd0);
    cyc(1, 0, 1, BUS_LOAD, 4'd9, 4'd0);
    cyc(0, 0, 1, BUS_STORE, 4'd9, 4'd0);
    cyc(1, 0, 1, BUS_LOAD, 4'd9, 4'd4);
    cyc(0, 0, 1, BUS_LOAD, 4'd4, 4'd0);
    drain();

    // Randomized traffic with squashes and same-cycle tag reuse.
    ic_p = 0; dc_p = 0; dcmd = BUS_LOAD;
    for (int n = 0; n < 2500; n++) begin
      if (!ic_p && $urandom_range(0, 2) == 0) ic_p = 1;
      if (!dc_p && $urandom_range(0, 1) == 0) begin
        dc_p = 1;
        dcmd = ($urandom_range(0, 3) == 0) ? BUS_STORE : BUS_LOAD;
      end
      sq   = ($urandom_range(0, 9) == 0);
      resp = ($urandom_range(0, 3) == 0) ? 4'd0 : pick_free();
      rt   = (mem_inflight.size() > 0 && $urandom_range(0, 1) == 0) ?
             mem_inflight[$urandom_range(0, mem_inflight.size() - 1)] : 4'd0;
      if (rt != 0 && $urandom_range(0, 3) == 0) resp = rt;
      cyc(ic_p, sq, dc_p, dcmd, resp, rt);
      if (m_ic_acc) ic_p = 0;
      if (m_dc_acc) dc_p = 0;
    end
    drain();
    idle(1);

    // Return to an unallocated tag sets a sticky error.
    cyc(0, 0, 0, BUS_NONE, 4'd0, 4'd7);
    idle(3);

    // Mid-flight reset discards tags; their later returns flag errors.
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, BUS_LOAD, pick_free(), 4'd0);
    idle(1);
    #1;
    reset = 1'b0;
    ic_req = 1; dc_req = 1; dc_cmd = BUS_LOAD; mem2proc_response = 4'd2;
    model_clear();
    #1;
    check("reset_cnt_async", outstanding_cnt, 5'd0);
    check("reset_cmd_async", proc2mem_command, BUS_NONE);
    check("reset_accept_async", {ic_accept, dc_accept}, 2'b00);
    check("reset_err_async", tag_err, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, BUS_LOAD, 4'd2, 4'd0);
    idle(1);
    reset = 1'b1;
    drain();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
